id_hazard_tracker: RTL and testbench
====================================

# id_hazard_tracker

Producer-side companion to the ID-stage forwarding select. It shadows the EXE/MEM/MEM2/WB pipeline with a register-write tag per stage, recording which stage each in-flight result becomes available in. From these tags it emits the 3-bit forward selects for ID only when the selected producer already holds valid data. Otherwise it raises a load-use/multi-cycle stall. It also tracks the iterative divider's busy window for HI/LO readers.

## Interface
- DIV_CYCLES, 34, cycles from divide issue (entering EXE) until HI/LO results are valid; 2..63
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- Adv  in  1  downstream pipeline advances this cycle (EXE accepts from ID)
- Flush  in  1  exception/branch flush: kills ID, EXE, MEM contents
- ID_Valid  in  1  instruction present in ID
- ID_RFWr  in  1  ID instruction writes GPR
- ID_Dst  in  5  ID destination register
- ID_AvailStage  in  2  stage where its result is first valid: 0=EXE, 1=MEM, 2=MEM2, 3=WB
- ID_rs, ID_rt  in  5 each  ID source registers
- ID_UsesRs, ID_UsesRt  in  1 each  source actually read
- ID_IsDiv  in  1  ID instruction starts a divide
- ID_ReadsHiLo  in  1  ID instruction reads HI/LO (mfhi/mflo/madd family)
- ID_ForwardA, ID_ForwardB  out  3 each  000 reg file, 001 EXE, 010 MEM, 011 MEM2, 100 WB
- ID_Stall  out  1  hold ID/IF, inject bubble into EXE
- DivBusy  out  1  divider window open

## Operation
- Per stage S in {EXE, MEM, MEM2, WB}: registered tag {V, Wr, Dst[4:0], Avail[1:0]}. Stage index: EXE=0, MEM=1, MEM2=2, WB=3.
- Producer match for source r in stage S: V && Wr && Dst!=0 && Dst==r.
- Source resolution: take the youngest matching stage (EXE first, then MEM, MEM2, WB).
  - If that stage's index >= its Avail: forward code = stage code.
  - Otherwise: source hazard, code = 000.
  - No match: 000.
  - An unused source (UsesRx=0) never creates a hazard; its forward code is still computed.
- ID_Stall = ID_Valid && (hazard on a used rs || hazard on a used rt || (ID_ReadsHiLo && DivBusy) || (ID_IsDiv && DivBusy)).
- Tag shift on Adv=1:
  - WB<=MEM2, MEM2<=MEM, MEM<=EXE.
  - EXE<=ID tag, with V = ID_Valid && !ID_Stall.
  - Adv=0: all tags hold.
- Flush (priority over Adv): EXE.V<=0, MEM.V<=0. MEM2 and WB shift normally if Adv=1, otherwise hold.
- Divider counter, 6 bits:
  - Loads DIV_CYCLES when a divide enters EXE (Adv && ID_Valid && ID_IsDiv && !ID_Stall && !Flush).
  - Otherwise decrements by 1 per cycle while nonzero, independent of Adv.
  - DivBusy = counter != 0.
  - Flush clears the counter only if the divide tag is still in EXE or MEM. Track this with a 1-bit DivYoung flag set on load and cleared when the tag shifts out of MEM.

## Timing
- ID_Forward*, ID_Stall, DivBusy: combinational from registered state plus current ID inputs; zero-cycle latency.
- Tag and counter state update on posedge clk.
- Reset (resetn=0, asynchronous): all V=0, counter=0, DivYoung=0. Outputs then read ID_ForwardA/B=000, DivBusy=0, and ID_Stall=0 unless ID inputs alone require it (impossible with all V=0 and DivBusy=0).
- Load-use, load with Avail=MEM2 consumed back-to-back:
  - 2 stall cycles (producer in EXE, then in MEM).
  - Forward 011 on the third cycle.
  - Assumes Adv=1 throughout.
- ALU result (Avail=EXE) consumed next instruction: 001, no stall.
- Simultaneous stall and Adv: EXE receives a bubble, upstream holds; the hazard resolves as the producer advances.
- Adv=0 with stall: no state change, stall persists.
- Reset asserted mid-divide: counter drops to 0 immediately; DivBusy=0 asynchronously.
- Counter reaching 0 and a new divide arriving the same cycle: the new divide stalls while DivBusy=1. On the first cycle DivBusy=0 it issues and the counter reloads.

## Test plan
- Reset: hold resetn=0 with random ID inputs, then release with no traffic → ID_ForwardA/B=000, ID_Stall=0, DivBusy=0.
- ALU chain, Adv=1:
  - Issue "addu $5" (Avail=0), then "subu rs=$5" → ForwardA=001, no stall.
  - One instruction later, with the producer in MEM → 010.
- Load-use: lw $8 (Avail=2), then addu rt=$8 →
  - ID_Stall=1 for exactly 2 cycles.
  - ForwardB=011 on cycle 3.
  - EXE tag V=0 for the two bubble cycles.
- Priority and $0:
  - EXE and WB both write $3 → 001 selected.
  - A producer with Dst=$0 → 000, no stall.
- Flush: lw $9 in EXE, Flush=1 with Adv=1 → next cycle a $9 reader sees no match (000, no stall).
- Divider, DIV_CYCLES=4:
  - div enters EXE; mfhi in ID → stall for 4 cycles, DivBusy falls, mfhi issues.
  - resetn pulsed mid-window clears DivBusy immediately.

Source files
------------

// File: rtl/id_hazard_tracker.sv
// ID-stage hazard tracker: shadows EXE/MEM/MEM2/WB write tags to pick forward selects,
// raise load-use / HI-LO stalls, and time the iterative divider window.
module id_hazard_tracker #(
  parameter int DIV_CYCLES = 34
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       Adv,
  input  logic       Flush,
  input  logic       ID_Valid,
  input  logic       ID_RFWr,
  input  logic [4:0] ID_Dst,
  input  logic [1:0] ID_AvailStage,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       ID_IsDiv,
  input  logic       ID_ReadsHiLo,
  output logic [2:0] ID_ForwardA,
  output logic [2:0] ID_ForwardB,
  output logic       ID_Stall,
  output logic       DivBusy
);

  // Stage index: 0=EXE, 1=MEM, 2=MEM2, 3=WB
  logic [3:0]      r_v;
  logic [3:0]      r_wr;
  logic [3:0][4:0] r_dst;
  logic [3:0][1:0] r_avail;

  logic [5:0] r_div_cnt;
  logic       r_div_young;
  logic       r_div_in_mem;

  logic [2:0] w_fwd_a;
  logic [2:0] w_fwd_b;
  logic       w_haz_a;
  logic       w_haz_b;
  logic       w_stall;
  logic       w_div_issue;

  // Walk oldest to youngest so the youngest matching producer wins.
  always_comb begin
    w_fwd_a = 3'b000;
    w_fwd_b = 3'b000;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (r_v[i] && r_wr[i] && (r_dst[i] != 5'd0) && (r_dst[i] == ID_rs)) begin
        if (2'(i) >= r_avail[i]) begin
          w_fwd_a = 3'(i + 1);
          w_haz_a = 1'b0;
        end else begin
          w_fwd_a = 3'b000;
          w_haz_a = 1'b1;
        end
      end
      if (r_v[i] && r_wr[i] && (r_dst[i] != 5'd0) && (r_dst[i] == ID_rt)) begin
        if (2'(i) >= r_avail[i]) begin
          w_fwd_b = 3'(i + 1);
          w_haz_b = 1'b0;
        end else begin
          w_fwd_b = 3'b000;
          w_haz_b = 1'b1;
        end
      end
    end
  end

  assign DivBusy     = (r_div_cnt != 6'd0);
  assign w_stall     = ID_Valid && ((w_haz_a && ID_UsesRs) || (w_haz_b && ID_UsesRt) ||
                                    ((ID_ReadsHiLo || ID_IsDiv) && DivBusy));
  assign w_div_issue = Adv && ID_Valid && ID_IsDiv && !w_stall && !Flush;

  assign ID_ForwardA = w_fwd_a;
  assign ID_ForwardB = w_fwd_b;
  assign ID_Stall    = w_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v     <= '0;
      r_wr    <= '0;
      r_dst   <= '0;
      r_avail <= '0;
    end else if (Adv) begin
      r_v[3]     <= r_v[2];
      r_wr[3]    <= r_wr[2];
      r_dst[3]   <= r_dst[2];
      r_avail[3] <= r_avail[2];
      r_v[2]     <= r_v[1];
      r_wr[2]    <= r_wr[1];
      r_dst[2]   <= r_dst[1];
      r_avail[2] <= r_avail[1];
      r_v[1]     <= r_v[0] && !Flush;
      r_wr[1]    <= r_wr[0];
      r_dst[1]   <= r_dst[0];
      r_avail[1] <= r_avail[0];
      r_v[0]     <= ID_Valid && !w_stall && !Flush;
      r_wr[0]    <= ID_RFWr;
      r_dst[0]   <= ID_Dst;
      r_avail[0] <= ID_AvailStage;
    end else if (Flush) begin
      r_v[0] <= 1'b0;
      r_v[1] <= 1'b0;
    end
  end

  // The divide may only be cancelled by a flush while its tag is still in EXE or MEM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div_cnt    <= 6'd0;
      r_div_young  <= 1'b0;
      r_div_in_mem <= 1'b0;
    end else if (w_div_issue) begin
      r_div_cnt    <= 6'(DIV_CYCLES);
      r_div_young  <= 1'b1;
      r_div_in_mem <= 1'b0;
    end else if (Flush && r_div_young) begin
      r_div_cnt    <= 6'd0;
      r_div_young  <= 1'b0;
      r_div_in_mem <= 1'b0;
    end else begin
      if (r_div_cnt != 6'd0) r_div_cnt <= r_div_cnt - 6'd1;
      if (Adv && r_div_young) begin
        if (r_div_in_mem) begin
          r_div_young  <= 1'b0;
          r_div_in_mem <= 1'b0;
        end else begin
          r_div_in_mem <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_tracker.sv
// Directed bench for id_hazard_tracker: forwarding, load-use stalls, flush and divider window.
module tb_id_hazard_tracker;
  logic       clk = 1'b0;
  logic       resetn;
  logic       Adv;
  logic       Flush;
  logic       ID_Valid;
  logic       ID_RFWr;
  logic [4:0] ID_Dst;
  logic [1:0] ID_AvailStage;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic       ID_IsDiv;
  logic       ID_ReadsHiLo;
  logic [2:0] ID_ForwardA;
  logic [2:0] ID_ForwardB;
  logic       ID_Stall;
  logic       DivBusy;

  int n_checks = 0;
  int n_errors = 0;

  id_hazard_tracker #(.DIV_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .Adv(Adv), .Flush(Flush),
    .ID_Valid(ID_Valid), .ID_RFWr(ID_RFWr), .ID_Dst(ID_Dst), .ID_AvailStage(ID_AvailStage),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsDiv(ID_IsDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .ID_ForwardA(ID_ForwardA), .ID_ForwardB(ID_ForwardB), .ID_Stall(ID_Stall), .DivBusy(DivBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic [4:0] dst, input logic [1:0] av,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic dv, input logic hl);
    ID_Valid = v; ID_RFWr = wr; ID_Dst = dst; ID_AvailStage = av;
    ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_IsDiv = dv; ID_ReadsHiLo = hl;
  endtask

  task automatic nop();
    drive(0, 0, 5'd0, 2'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (5) tick();
  endtask

  initial begin
    resetn = 1'b0; Adv = 1'b1; Flush = 1'b0;
    drive(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    #2;
    chk("rst_fwdA_in_reset", ID_ForwardA, 0);
    chk("rst_stall_in_reset", ID_Stall, 0);
    repeat (2) @(posedge clk);
    #1;
    nop();
    resetn = 1'b1;
    #1;
    chk("rst_fwdA", ID_ForwardA, 0);
    chk("rst_fwdB", ID_ForwardB, 0);
    chk("rst_stall", ID_Stall, 0);
    chk("rst_divbusy", DivBusy, 0);
    tick();

    // ALU chain: addu $5 then two readers of $5
    drive(1, 1, 5'd5, 2'd0, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    drive(1, 1, 5'd6, 2'd0, 5'd5, 5'd2, 1, 1, 0, 0);
    #1;
    chk("alu_exe_fwdA", ID_ForwardA, 1);
    chk("alu_exe_stall", ID_Stall, 0);
    tick();
    drive(1, 1, 5'd7, 2'd0, 5'd5, 5'd0, 1, 0, 0, 0);
    #1;
    chk("alu_mem_fwdA", ID_ForwardA, 2);
    chk("alu_mem_stall", ID_Stall, 0);
    drain();

    // Load-use: lw $8 (MEM2) then addu rt=$8
    drive(1, 1, 5'd8, 2'd2, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    drive(1, 1, 5'd10, 2'd0, 5'd1, 5'd8, 1, 1, 0, 0);
    #1;
    chk("lu_c1_stall", ID_Stall, 1);
    chk("lu_c1_fwdB", ID_ForwardB, 0);
    tick();
    chk("lu_c2_stall", ID_Stall, 1);
    chk("lu_c2_exe_v", dut.r_v[0], 0);
    tick();
    chk("lu_c3_stall", ID_Stall, 0);
    chk("lu_c3_fwdB", ID_ForwardB, 3);
    chk("lu_c3_exe_v", dut.r_v[0], 0);
    tick();
    chk("lu_issued_exe_v", dut.r_v[0], 1);
    drain();

    // Unused source with pending hazard does not stall
    drive(1, 1, 5'd8, 2'd2, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    drive(1, 1, 5'd11, 2'd0, 5'd8, 5'd0, 0, 0, 0, 0);
    #1;
    chk("unused_stall", ID_Stall, 0);
    chk("unused_fwdA", ID_ForwardA, 0);
    drain();

    // Adv=0 with stall: nothing moves, stall persists
    drive(1, 1, 5'd8, 2'd2, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    drive(1, 1, 5'd10, 2'd0, 5'd1, 5'd8, 1, 1, 0, 0);
    Adv = 1'b0;
    #1;
    chk("hold_c1_stall", ID_Stall, 1);
    tick();
    chk("hold_c2_stall", ID_Stall, 1);
    chk("hold_exe_v", dut.r_v[0], 1);
    Adv = 1'b1;
    drain();

    // WB-available producer: three stalls then forward from WB
    drive(1, 1, 5'd7, 2'd3, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    drive(1, 1, 5'd12, 2'd0, 5'd7, 5'd2, 1, 1, 0, 0);
    #1;
    chk("wb_c1_stall", ID_Stall, 1);
    tick();
    chk("wb_c2_stall", ID_Stall, 1);
    tick();
    chk("wb_c3_stall", ID_Stall, 1);
    tick();
    chk("wb_c4_stall", ID_Stall, 0);
    chk("wb_c4_fwdA", ID_ForwardA, 4);
    drain();

    // Priority: EXE and WB both write $3
    drive(1, 1, 5'd3, 2'd0, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    nop();
    repeat (2) tick();
    drive(1, 1, 5'd3, 2'd0, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    drive(1, 1, 5'd13, 2'd0, 5'd3, 5'd3, 1, 0, 0, 0);
    #1;
    chk("prio_fwdA", ID_ForwardA, 1);
    chk("prio_fwdB", ID_ForwardB, 1);
    chk("prio_stall", ID_Stall, 0);
    drain();

    // $0 producer never matches
    drive(1, 1, 5'd0, 2'd3, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    drive(1, 1, 5'd14, 2'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    #1;
    chk("zero_fwdA", ID_ForwardA, 0);
    chk("zero_stall", ID_Stall, 0);
    drain();

    // Flush kills lw $9 in EXE
    drive(1, 1, 5'd9, 2'd2, 5'd1, 5'd2, 1, 1, 0, 0);
    tick();
    nop();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    drive(1, 1, 5'd15, 2'd0, 5'd1, 5'd9, 1, 1, 0, 0);
    #1;
    chk("flush_fwdB", ID_ForwardB, 0);
    chk("flush_stall", ID_Stall, 0);
    drain();

    // Divider window of 4 cycles blocks mfhi
    drive(1, 0, 5'd0, 2'd0, 5'd4, 5'd5, 1, 1, 1, 0);
    #1;
    chk("div_issue_stall", ID_Stall, 0);
    chk("div_pre_busy", DivBusy, 0);
    tick();
    drive(1, 1, 5'd2, 2'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    #1;
    chk("div_busy", DivBusy, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("div_mfhi_stall%0d", i), ID_Stall, 1);
      tick();
    end
    chk("div_done_busy", DivBusy, 0);
    chk("div_mfhi_go", ID_Stall, 0);
    tick();
    chk("div_mfhi_exe_v", dut.r_v[0], 1);
    drain();

    // Reset mid-window drops DivBusy asynchronously
    drive(1, 0, 5'd0, 2'd0, 5'd4, 5'd5, 1, 1, 1, 0);
    tick();
    nop();
    tick();
    chk("rstdiv_busy_before", DivBusy, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstdiv_busy_async", DivBusy, 0);
    #1;
    resetn = 1'b1;
    drain();

    // Flush while divide is still young cancels the window
    drive(1, 0, 5'd0, 2'd0, 5'd4, 5'd5, 1, 1, 1, 0);
    tick();
    nop();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flushdiv_busy", DivBusy, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
